// File: rtl/huff_job_ctrl.sv
// Job sequencer for the Huffman tree engine: loads a job, starts the engine, waits for
// completion under a watchdog, then streams the code table over a valid/ready port.
module huff_job_ctrl #(
    parameter int MAX_SYM = 8,
    parameter int GN_W    = 6,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [GN_W-1:0] req_gnumber,
    output logic            eng_start,
    output logic [GN_W-1:0] eng_gnumber,
    input  logic            eng_done,
    output logic [GN_W-1:0] eng_addr,
    input  logic [7:0]      eng_result,
    input  logic [2:0]      eng_len,
    input  logic [7:0]      eng_code,
    output logic            tab_valid,
    input  logic            tab_ready,
    output logic [7:0]      tab_sym,
    output logic [2:0]      tab_len,
    output logic [7:0]      tab_code,
    output logic            tab_last,
    output logic            job_done,
    output logic            err_timeout,
    output logic            err_range,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    // Valid/ready: a beat (or request) transfers on a rising edge where valid and
    // ready are both high; valid never waits on ready, and the beat holds until taken.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    localparam logic [GN_W-1:0] MAX_GN  = GN_W'(MAX_SYM);
    localparam logic [GN_W-1:0] GN_ONE  = GN_W'(1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [GN_W-1:0] load_cnt;
    logic [TO_W-1:0] wdog;
    logic            seen_low;
    logic [GN_W-1:0] gn_req;
    logic            eng_finished;
    logic            run_expired;

    assign gn_req       = (req_gnumber > MAX_GN) ? MAX_GN : req_gnumber;
    // A done that has not yet been seen low is the stale idle level, not completion.
    assign eng_finished = eng_done && seen_low;
    assign run_expired  = (wdog == TO_LAST) && !eng_finished;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign eng_start = (state == S_LOAD);
    assign tab_valid = (state == S_DRAIN);
    assign tab_last  = (state == S_DRAIN) && (eng_addr == eng_gnumber - GN_ONE);
    assign tab_sym   = eng_result;
    assign tab_len   = eng_len;
    assign tab_code  = eng_code;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (req_valid && (gn_req != '0)) state_n = S_LOAD;
            end
            S_LOAD: begin
                if (load_cnt == eng_gnumber - GN_ONE) state_n = S_RUN;
            end
            S_RUN: begin
                if (eng_finished)     state_n = S_DRAIN;
                else if (run_expired) state_n = S_IDLE;
            end
            S_DRAIN: begin
                if (tab_ready && tab_last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_gnumber <= '0;
            eng_addr    <= '0;
            load_cnt    <= '0;
            wdog        <= '0;
            seen_low    <= 1'b0;
            job_done    <= 1'b0;
            err_timeout <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            job_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        eng_gnumber <= gn_req;
                        err_range   <= (req_gnumber > MAX_GN);
                        err_timeout <= 1'b0;
                        load_cnt    <= '0;
                        eng_addr    <= '0;
                        if (gn_req == '0) job_done <= 1'b1;
                    end
                end
                S_LOAD: begin
                    load_cnt <= load_cnt + GN_ONE;
                    wdog     <= '0;
                    seen_low <= 1'b0;
                end
                S_RUN: begin
                    wdog <= wdog + TO_ONE;
                    if (!eng_done) seen_low <= 1'b1;
                    if (run_expired) err_timeout <= 1'b1;
                end
                S_DRAIN: begin
                    if (tab_ready) begin
                        if (tab_last) begin
                            eng_addr <= '0;
                            job_done <= 1'b1;
                        end else begin
                            eng_addr <= eng_addr + GN_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_job_ctrl.sv
// Self-checking bench for huff_job_ctrl: behavioural engine and sink, a negedge monitor
// feeding queues/counters, and one task per scenario compared against a table model.
module tb_huff_job_ctrl;

    localparam int GN_W    = 6;
    localparam int MAX_SYM = 8;
    localparam int TIMEOUT = 1023;
    localparam int BW      = GN_W + 8 + 3 + 8 + 1;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [GN_W-1:0] req_gnumber;
    logic            eng_start;
    logic [GN_W-1:0] eng_gnumber;
    logic            eng_done;
    logic [GN_W-1:0] eng_addr;
    logic [7:0]      eng_result;
    logic [2:0]      eng_len;
    logic [7:0]      eng_code;
    logic            tab_valid;
    logic            tab_ready;
    logic [7:0]      tab_sym;
    logic [2:0]      tab_len;
    logic [7:0]      tab_code;
    logic            tab_last;
    logic            job_done;
    logic            err_timeout;
    logic            err_range;
    logic            busy;
    logic [1:0]      dbg_state;

    huff_job_ctrl #(.MAX_SYM(MAX_SYM), .GN_W(GN_W), .TIMEOUT(TIMEOUT), .TO_W(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_gnumber(req_gnumber),
        .eng_start(eng_start), .eng_gnumber(eng_gnumber), .eng_done(eng_done),
        .eng_addr(eng_addr), .eng_result(eng_result), .eng_len(eng_len), .eng_code(eng_code),
        .tab_valid(tab_valid), .tab_ready(tab_ready), .tab_sym(tab_sym), .tab_len(tab_len),
        .tab_code(tab_code), .tab_last(tab_last), .job_done(job_done),
        .err_timeout(err_timeout), .err_range(err_range), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- engine model: table contents keyed per job ----------------
    logic [31:0] key;
    logic        eng_hang;

    function automatic logic [7:0] sym_of(input int a, input logic [31:0] k);
        return 8'((a * 37 + int'(k[7:0])) % 256);
    endfunction
    function automatic logic [2:0] len_of(input int a, input logic [31:0] k);
        return 3'((a + int'(k[10:8])) % 8);
    endfunction
    function automatic logic [7:0] code_of(input int a, input logic [31:0] k);
        return 8'((a * 13) % 256) ^ k[23:16];
    endfunction

    assign eng_result = sym_of(int'(eng_addr), key);
    assign eng_len    = len_of(int'(eng_addr), key);
    assign eng_code   = code_of(int'(eng_addr), key);

    initial begin
        eng_done = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (eng_start && !eng_hang && rst) begin
                @(posedge clk); #1 eng_done = 1'b0;
                repeat (20) @(posedge clk);
                #1 eng_done = 1'b1;
            end
        end
    end

    // ---------------- sink ----------------
    int ready_mode = 0;
    int sink_ph    = 0;
    initial begin
        tab_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            sink_ph++;
            case (ready_mode)
                0:       tab_ready = 1'b1;
                1:       tab_ready = (sink_ph % 3 == 0);
                default: tab_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard queues ----------------
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_q[$];
    logic [BW-1:0] cur_beat, prev_beat;
    logic          prev_stall = 1'b0;
    int cyc = 0, start_cnt = 0, done_cnt = 0, valid_cnt = 0, run_cnt = 0, stall_bad = 0;
    int done_cyc = -1, acc_cyc = -1, hs_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (eng_start) start_cnt++;
            if (job_done) begin done_cnt++; done_cyc = cyc; end
            if (tab_valid) valid_cnt++;
            if (busy && !eng_start && !tab_valid) run_cnt++;
            if (req_valid && req_ready) acc_cyc = cyc;
            cur_beat = {eng_addr, tab_sym, tab_len, tab_code, tab_last};
            if (tab_valid && prev_stall && (cur_beat !== prev_beat)) stall_bad++;
            prev_stall = tab_valid && !tab_ready;
            prev_beat  = cur_beat;
            if (tab_valid && tab_ready) begin got_q.push_back(cur_beat); hs_cyc = cyc; end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        start_cnt = 0; done_cnt = 0; valid_cnt = 0; run_cnt = 0; stall_bad = 0;
        got_q.delete();
    endtask

    // Expected table: one beat per symbol of the clamped job, last flag on the final one.
    task automatic build_exp(input int gn);
        int g;
        g = (gn > MAX_SYM) ? MAX_SYM : gn;
        exp_q.delete();
        for (int a = 0; a < g; a++)
            exp_q.push_back({GN_W'(a), sym_of(a, key), len_of(a, key), code_of(a, key), (a == g - 1)});
    endtask

    task automatic issue_req(input int gn);
        req_gnumber = GN_W'(gn);
        for (int i = 0; i < 3000; i++) begin
            if (req_ready) begin
                req_valid = 1'b1;
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL req_accept got no_ready exp ready within 3000 cycles");
    endtask

    task automatic wait_end();
        for (int i = 0; i < 3000; i++) begin
            if (!busy && !job_done) return;
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL job_end got busy exp idle within 3000 cycles");
    endtask

    task automatic run_job(input int gn, input int mode);
        key = $urandom;
        ready_mode = mode;
        clear_mon();
        build_exp(gn);
        issue_req(gn);
        wait_end();
    endtask

    task automatic check_table(input string name);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_beats got %0d exp %0d", name, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_beat%0d got %h exp %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if ({busy, eng_start, tab_valid, tab_last, job_done} !== 5'b0) begin
            errors++; $display("FAIL rst_ctl got %b exp 00000", {busy, eng_start, tab_valid, tab_last, job_done}); end
        checks++; if ({err_timeout, err_range} !== 2'b0) begin
            errors++; $display("FAIL rst_err got %b exp 00", {err_timeout, err_range}); end
        checks++; if ({eng_gnumber, eng_addr} !== '0) begin
            errors++; $display("FAIL rst_gn_addr got %h exp 0", {eng_gnumber, eng_addr}); end
    endtask

    task automatic test_basic();
        run_job(4, 0);
        check_table("basic");
        checks++; if (start_cnt !== 4) begin errors++; $display("FAIL basic_start got %0d exp 4", start_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
        checks++; if (done_cyc !== hs_cyc + 1) begin errors++; $display("FAIL basic_done_lat got %0d exp %0d", done_cyc, hs_cyc + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
        checks++; if (eng_gnumber !== GN_W'(4)) begin errors++; $display("FAIL basic_gn got %0d exp 4", eng_gnumber); end
    endtask

    task automatic test_backpressure();
        run_job(4, 1);
        check_table("bp");
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", stall_bad); end
        checks++; if (valid_cnt <= 4) begin errors++; $display("FAIL bp_stalls got %0d exp >4", valid_cnt); end
    endtask

    task automatic test_range();
        run_job(12, 2);
        check_table("range");
        checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", err_range); end
        checks++; if (eng_gnumber !== GN_W'(MAX_SYM)) begin errors++; $display("FAIL range_gn got %0d exp %0d", eng_gnumber, MAX_SYM); end
        checks++; if (start_cnt !== MAX_SYM) begin errors++; $display("FAIL range_start got %0d exp %0d", start_cnt, MAX_SYM); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL range_stable got %0d exp 0", stall_bad); end
    endtask

    task automatic test_zero();
        run_job(0, 0);
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL zero_range_clr got %b exp 0", err_range); end
        checks++; if (start_cnt !== 0) begin errors++; $display("FAIL zero_start got %0d exp 0", start_cnt); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL zero_valid got %0d exp 0", valid_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt got %0d exp 1", done_cnt); end
        checks++; if (done_cyc !== acc_cyc + 1) begin errors++; $display("FAIL zero_done_lat got %0d exp %0d", done_cyc, acc_cyc + 1); end
    endtask

    task automatic test_timeout();
        eng_hang = 1'b1;
        run_job(3, 0);
        eng_hang = 1'b0;
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err_timeout); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL to_ready got %b exp 1", req_ready); end
        checks++; if (run_cnt !== TIMEOUT) begin errors++; $display("FAIL to_run_cycles got %0d exp %0d", run_cnt, TIMEOUT); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL to_done got %0d exp 0", done_cnt); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL to_valid got %0d exp 0", valid_cnt); end
        run_job($urandom_range(1, MAX_SYM), 2);
        check_table("to_next");
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", err_timeout); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        key = $urandom;
        ready_mode = 0;
        clear_mon();
        build_exp(5);
        issue_req(5);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (got_q.size() >= 2) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!hit || tab_valid !== 1'b1) begin errors++; $display("FAIL mid_reach got %b exp 1", tab_valid); end
        rst = 1'b0;
        #1;
        checks++; if ({tab_valid, eng_start, busy, job_done} !== 4'b0) begin
            errors++; $display("FAIL mid_ctl got %b exp 0000", {tab_valid, eng_start, busy, job_done}); end
        checks++; if ({eng_addr, eng_gnumber} !== '0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_state got %h/%b exp 0/1", {eng_addr, eng_gnumber}, req_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", done_cnt); end
        run_job($urandom_range(1, MAX_SYM), 1);
        check_table("mid_next");
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mid_next_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int gn;
        for (int j = 0; j < 5; j++) begin
            gn = $urandom_range(1, MAX_SYM);
            key = $urandom;
            ready_mode = $urandom_range(0, 2);
            clear_mon();
            build_exp(gn);
            issue_req(gn);
            if (j > 0) begin
                checks++; if (acc_cyc !== done_cyc) begin errors++; $display("FAIL b2b_accept_in_done got %0d exp %0d", acc_cyc, done_cyc); end
            end
            for (int i = 0; i < 500; i++) begin
                if (got_q.size() >= gn) break;
                @(posedge clk); #1;
            end
            check_table("b2b");
            checks++; if (req_ready !== 1'b1 || job_done !== 1'b1) begin
                errors++; $display("FAIL b2b_done_cycle got %b%b exp 11", req_ready, job_done); end
        end
        wait_end();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b0;
        req_valid = 1'b0;
        req_gnumber = '0;
        eng_hang = 1'b0;
        key = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_backpressure();
        test_range();
        test_zero();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
